// File: rtl/sc_dec_pkg.sv
// Shared types and helpers for the stochastic stream decoder.
// The default window width is 8 bits, which gives a 256-sample window.
// When SC_DEC_BIPOLAR_EN is defined, the top converts the count to a signed bipolar value.
package sc_dec_pkg;

  localparam int INWD_DEF = 8;
  localparam int WIN_LEN  = 2**INWD_DEF;
  localparam int RES_W    = INWD_DEF + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } dec_state_t;

  // Returns the window length in samples for a given log2 width.
  function automatic int win_len(input int inwd);
    return 1 << inwd;
  endfunction

endpackage

// File: rtl/sc_ones_acc.sv
// Window counter and ones accumulator.
// The accumulator is one bit wider than the counter, so an all-ones window fits.
// 'last' flags that the next enabled sample is the final sample of the window.
module sc_ones_acc
  import sc_dec_pkg::*;
#(
  parameter int INWD = INWD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          bitIn,
  output logic [INWD:0] acc,
  output logic          last
);

  logic [INWD-1:0] win_cnt;

  // Clear on window start; when enabled, count the sample and add the bit.
  // The counter wraps to 0 on the final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (clr) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (en) begin
      acc     <= acc + (INWD+1)'(bitIn);
      win_cnt <= win_cnt + INWD'(1);
    end
  end

  assign last = (win_cnt == '1);

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter.
// Counts the ones in a window of 2**INWD enabled samples.
// The count is presented on 'result' together with a one-cycle 'outValid' pulse.
// Optional macro SC_DEC_BIPOLAR_EN: the result becomes 2*ones - 2**INWD.
// In that mode the result is signed and clamped at +(2**INWD-1).
module sc_stream_decoder
  import sc_dec_pkg::*;
#(
  parameter int INWD = INWD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          start,
  input  logic          bitIn,
  output logic          busy,
  output logic          outValid,
  output logic [INWD:0] result
);

  localparam int RW = INWD + 1;

  dec_state_t      state_reg;
  dec_state_t      state_next;
  logic            clr;
  logic            en;
  logic            last;
  logic            load;
  logic [INWD:0]   acc;
  logic [INWD:0]   final_acc;
  logic [INWD:0]   conv;
  logic [INWD:0]   result_reg;

  sc_ones_acc #(
    .INWD (INWD)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (en),
    .bitIn (bitIn),
    .acc   (acc),
    .last  (last)
  );

  // Next-state and counter control.
  // A start outside IDLE is ignored.
  always_comb begin
    state_next = state_reg;
    clr        = 1'b0;
    en         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          clr        = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        en = enable;
        if (enable && last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The final sample has not yet been added to acc, so fold it in here.
  // This lets the result register load on the same edge that enters DONE.
  assign load      = en && last;
  assign final_acc = acc + RW'(bitIn);

`ifdef SC_DEC_BIPOLAR_EN
  localparam logic [INWD:0] WIN_W = RW'(win_len(INWD));
  logic [INWD:0] twice;

  // Bipolar mapping: 2*ones - 2**INWD, clamping the single overflow case.
  always_comb begin
    twice = {final_acc[INWD-1:0], 1'b0} - WIN_W;
    if (final_acc == WIN_W) begin
      conv = WIN_W - RW'(1);
    end else begin
      conv = twice;
    end
  end
`else
  assign conv = final_acc;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the converted count at the end of the window.
  // It then holds until the next window completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
    end else if (load) begin
      result_reg <= conv;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign outValid = (state_reg == DONE);
  assign result   = result_reg;

endmodule
